// File: rtl/processor.sv
// Multi-cycle 16-bit register-transfer processor: R0..R7, accumulator A, result G, shared bus.
// Optional feature macro PROCESSOR_SUB_EN enables opcode 011 = SUB Rx Ry.
module processor (
    input  logic        clk,
    input  logic        resetn,
    input  logic [24:0] func,
    input  logic        new_func,
    output logic [4:0]  cur_state,
    output logic [15:0] bus,
    output logic [15:0] data,
    output logic [19:0] ous
);

    typedef enum logic [4:0] {
        S_WAIT   = 5'd0,
        S_DECODE = 5'd1,
        S_LOAD   = 5'd2,
        S_MOV    = 5'd3,
        S_ALU_A  = 5'd4,
        S_ALU_G  = 5'd5,
        S_ALU_WB = 5'd6
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] r_q [8];
    logic [15:0] a_q;
    logic [15:0] g_q;
    logic [24:0] ir_q;
    logic        done_q;
    logic [2:0]  rx, ry;
    logic [15:0] alu_res;

    assign rx = ir_q[21:19];
    assign ry = ir_q[18:16];

    always_comb begin
        bus = '0;
        case (state_q)
            S_LOAD:   bus = ir_q[15:0];
            S_MOV:    bus = r_q[ry];
            S_ALU_A:  bus = r_q[rx];
            S_ALU_G:  bus = r_q[ry];
            S_ALU_WB: bus = g_q;
            default:  bus = '0;
        endcase
    end

`ifdef PROCESSOR_SUB_EN
    // Only opcodes 010 and 011 reach the ALU states, so bit 22 selects SUB.
    assign alu_res = ir_q[22] ? (a_q - bus) : (a_q + bus);
`else
    assign alu_res = a_q + bus;
`endif

    // DECODE dispatches on func, i.e. the same word IR latches on this edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   state_d = new_func ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case (func[24:22])
                    3'b000:  state_d = S_LOAD;
                    3'b001:  state_d = S_MOV;
                    3'b010:  state_d = S_ALU_A;
`ifdef PROCESSOR_SUB_EN
                    3'b011:  state_d = S_ALU_A;
`endif
                    default: state_d = S_WAIT;
                endcase
            end
            S_ALU_A:  state_d = S_ALU_G;
            S_ALU_G:  state_d = S_ALU_WB;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_WAIT;
            done_q  <= 1'b0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int unsigned i = 0; i < 8; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_LOAD) || (state_d == S_MOV) || (state_d == S_ALU_WB);
            if (state_q == S_WAIT || state_q == S_DECODE) ir_q <= func;
            case (state_q)
                S_LOAD, S_MOV, S_ALU_WB: r_q[rx] <= bus;
                S_ALU_A:                 a_q     <= bus;
                S_ALU_G:                 g_q     <= alu_res;
                default: ;
            endcase
        end
    end

    assign cur_state = state_q;
    assign data      = ir_q[15:0];
    assign ous       = {done_q, ir_q[24:22], r_q[0]};

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed program plus randomized instructions vs. a register-array model.
module tb_processor;

    logic        clk = 1'b0;
    logic        resetn;
    logic [24:0] func;
    logic        new_func;
    logic [4:0]  cur_state;
    logic [15:0] bus;
    logic [15:0] data;
    logic [19:0] ous;

    processor dut (
        .clk       (clk),
        .resetn    (resetn),
        .func      (func),
        .new_func  (new_func),
        .cur_state (cur_state),
        .bus       (bus),
        .data      (data),
        .ous       (ous)
    );

    always #5 clk = ~clk;

`ifdef PROCESSOR_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] m_r [8];

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One step of an executing instruction: check observable state, then scramble ignored inputs.
    task automatic exec_step(input string tag, input logic [4:0] st, input logic [15:0] b,
                             input logic dn, input logic [15:0] imm);
        chk({tag, "_state"}, 20'(cur_state), 20'(st));
        chk({tag, "_bus"},   20'(bus), 20'(b));
        chk({tag, "_done"},  20'(ous[19]), 20'(dn));
        chk({tag, "_data"},  20'(data), 20'(imm));
        func     = 25'($urandom);
        new_func = 1'($urandom);
        @(negedge clk);
    endtask

    // Called at a negedge while in WAIT; returns at a negedge back in WAIT.
    task automatic do_instr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                            input logic [15:0] imm);
        logic [24:0] fw;
        logic [15:0] res;
        fw       = {op, 3'($urandom), 3'($urandom), 16'($urandom)};
        func     = fw;
        new_func = 1'b1;
        @(negedge clk);
        chk("dec_state", 20'(cur_state), 20'd1);
        chk("dec_bus",   20'(bus), 20'd0);
        chk("dec_data",  20'(data), 20'(fw[15:0]));
        func     = {op, rx, ry, imm};
        new_func = 1'($urandom);
        @(negedge clk);
        if (op == 3'd0) begin
            exec_step("load", 5'd2, imm, 1'b1, imm);
            m_r[rx] = imm;
        end else if (op == 3'd1) begin
            exec_step("mov", 5'd3, m_r[ry], 1'b1, imm);
            m_r[rx] = m_r[ry];
        end else if (op == 3'd2 || (op == 3'd3 && SUB_EN)) begin
            res = (op == 3'd2) ? m_r[rx] + m_r[ry] : m_r[rx] - m_r[ry];
            exec_step("alu_a",  5'd4, m_r[rx], 1'b0, imm);
            exec_step("alu_g",  5'd5, m_r[ry], 1'b0, imm);
            exec_step("alu_wb", 5'd6, res,     1'b1, imm);
            m_r[rx] = res;
        end
        chk("wait_state", 20'(cur_state), 20'd0);
        chk("wait_bus",   20'(bus), 20'd0);
        chk("wait_ous",   ous, {1'b0, op, m_r[0]});
        new_func = 1'b0;
    endtask

    initial begin
        logic [2:0] rop;
        resetn   = 1'b0;
        func     = '0;
        new_func = 1'b0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 20'(cur_state), 20'd0);
        chk("rst_bus",   20'(bus), 20'd0);
        chk("rst_data",  20'(data), 20'd0);
        chk("rst_ous",   ous, 20'd0);
        resetn = 1'b1;
        @(negedge clk);

        do_instr(3'd0, 3'd0, 3'd0, 16'h0001);
        chk("r0_load1", 20'(ous[15:0]), 20'h0001);
        do_instr(3'd1, 3'd1, 3'd0, 16'h0000);
        chk("r0_after_mov", 20'(ous[15:0]), 20'h0001);
        do_instr(3'd2, 3'd0, 3'd1, 16'h0000);
        chk("r0_add1", 20'(ous[15:0]), 20'd2);
        do_instr(3'd2, 3'd0, 3'd1, 16'h0000);
        chk("r0_add2", 20'(ous[15:0]), 20'd3);
        do_instr(3'd2, 3'd0, 3'd1, 16'h0000);
        chk("r0_add3", 20'(ous[15:0]), 20'd4);
        do_instr(3'd0, 3'd2, 3'd0, 16'h0002);
        do_instr(3'd2, 3'd0, 3'd2, 16'h0000);
        chk("r0_add_r2", 20'(ous[15:0]), 20'd6);
        do_instr(3'd0, 3'd3, 3'd0, 16'hFFFF);
        do_instr(3'd2, 3'd3, 3'd2, 16'h0000);
        chk("r3_wrap", 20'(m_r[3]), 20'h0001);
        do_instr(3'd1, 3'd0, 3'd3, 16'h0000);
        chk("r0_eq_r3", 20'(ous[15:0]), 20'h0001);
        do_instr(3'd0, 3'd0, 3'd0, 16'h0006);
        do_instr(3'd3, 3'd0, 3'd1, 16'h0000);
        chk("r0_sub", 20'(ous[15:0]), SUB_EN ? 20'd5 : 20'd6);
        do_instr(3'd2, 3'd1, 3'd1, 16'h0000);
        do_instr(3'd1, 3'd0, 3'd1, 16'h0000);
        chk("r1_double", 20'(ous[15:0]), 20'd2);
        for (int op = 4; op < 8; op++) do_instr(3'(op), 3'($urandom), 3'($urandom), 16'($urandom));

        // Abort an ADD in ALU_G with an asynchronous reset.
        func     = {3'd2, 3'd0, 3'd1, 16'h0};
        new_func = 1'b1;
        @(negedge clk);
        new_func = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_state", 20'(cur_state), 20'd5);
        new_func = 1'b1;
        resetn   = 1'b0;
        #1;
        chk("abort_state", 20'(cur_state), 20'd0);
        chk("abort_ous",   ous, 20'd0);
        chk("abort_bus",   20'(bus), 20'd0);
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        @(negedge clk);
        chk("abort_hold", 20'(cur_state), 20'd0);
        resetn   = 1'b1;
        new_func = 1'b0;
        @(negedge clk);
        chk("post_abort_state", 20'(cur_state), 20'd0);

        for (int n = 0; n < 400; n++) begin
            rop = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
            do_instr(rop, 3'($urandom), 3'($urandom), 16'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                func = 25'($urandom);
                @(negedge clk);
                chk("idle_state", 20'(cur_state), 20'd0);
            end
        end
        // Read back every register through MOV R0,Rk.
        for (int k = 0; k < 8; k++) do_instr(3'd1, 3'd0, 3'(k), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
